// File: rtl/sound_irq_sequencer.sv
// sound_irq_sequencer: sticky sound-CPU interrupt request with ack, watchdog timeout and re-arm holdoff
module sound_irq_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd2048,
  parameter logic [7:0]  HOLDOFF = 8'd4
) (
  input  logic       clk_49m,
  input  logic       sirq_clr,
  input  logic       cen_sound,
  input  logic       trig_cen,
  input  logic       trig,
  input  logic       pause,
  output logic       z80_n_int,
  output logic       int_active,
  output logic       timeout_flag,
  output logic [3:0] coalesce_cnt,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, HOLD = 2'd2} state_t;
  state_t      state_q, state_d;
  logic        trig_q, trig_d, pend_q, pend_d, flag_q, flag_d;
  logic        n_int_q, n_int_d, act_q, act_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  coal_q, coal_d;
  logic        trig_edge, tick;
  assign trig_edge = trig_cen & trig & ~trig_q;
  assign tick      = cen_sound & ~pause;
  // next state: edge capture, pending request, counters and registered outputs
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    flag_d  = flag_q;
    coal_d  = coal_q;
    trig_d  = trig_cen ? trig : trig_q;
    case (state_q)
      IDLE: begin
        if (cen_sound & (pend_q | trig_edge)) begin
          state_d = ASSERT;
          pend_d  = 1'b0;
          timer_d = TIMEOUT;
        end else if (trig_edge) pend_d = 1'b1;
      end
      ASSERT: begin
        if (trig_edge && coal_q != 4'hf) coal_d = coal_q + 4'd1;
        if (tick && timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
          if (timer_q == 16'd1) begin
            state_d = HOLD;
            flag_d  = 1'b1;
            hold_d  = HOLDOFF;
          end
        end
      end
      HOLD: begin
        if (trig_edge) pend_d = 1'b1;
        if (tick && hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
          if (hold_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    n_int_d = state_d != ASSERT;
    act_d   = state_d == ASSERT;
  end
  // state registers; acknowledge clears everything asynchronously
  always_ff @(posedge clk_49m or posedge sirq_clr) begin
    if (sirq_clr) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      pend_q  <= 1'b0;
      timer_q <= 16'd0;
      hold_q  <= 8'd0;
      flag_q  <= 1'b0;
      coal_q  <= 4'd0;
      n_int_q <= 1'b1;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      flag_q  <= flag_d;
      coal_q  <= coal_d;
      n_int_q <= n_int_d;
      act_q   <= act_d;
    end
  end
  assign z80_n_int    = n_int_q;
  assign int_active   = act_q;
  assign timeout_flag = flag_q;
  assign coalesce_cnt = coal_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_sound_irq_sequencer.sv
// tb_sound_irq_sequencer: randomized and directed checks against a tick-counting reference model
module tb_sound_irq_sequencer;
  localparam int TO = 8, HO = 4;
  logic clk_49m = 1'b0;
  logic sirq_clr = 1'b1, cen_sound = 1'b0, trig_cen = 1'b0, trig = 1'b0, pause = 1'b0;
  logic z80_n_int, int_active, timeout_flag;
  logic [3:0] coalesce_cnt;
  logic [1:0] state_o;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_el = 0, m_coal = 0;
  bit m_pend = 0, m_prev = 0, m_flag = 0;
  int cyc = 0, acc = 0, tc_div = 16;
  bit frac = 0, tc_rand = 0;
  sound_irq_sequencer #(.TIMEOUT(16'(TO)), .HOLDOFF(8'(HO))) dut (
    .clk_49m(clk_49m), .sirq_clr(sirq_clr), .cen_sound(cen_sound), .trig_cen(trig_cen),
    .trig(trig), .pause(pause), .z80_n_int(z80_n_int), .int_active(int_active),
    .timeout_flag(timeout_flag), .coalesce_cnt(coalesce_cnt), .state_o(state_o)
  );
  always #10 clk_49m = ~clk_49m;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  // one clock: check outputs against the model, drive new inputs, advance the model over the next edge
  task automatic step(bit r, bit t, bit p);
    bit cs, tc, e;
    @(negedge clk_49m);
    chk("z80_n_int", 32'(z80_n_int), 32'(m_mode != 1));
    chk("int_active", 32'(int_active), 32'(m_mode == 1));
    chk("timeout_flag", 32'(timeout_flag), 32'(m_flag));
    chk("coalesce_cnt", 32'(coalesce_cnt), 32'(m_coal));
    chk("state_o", 32'(state_o), 32'(m_mode));
    cyc++;
    if (frac) begin
      acc += 50;
      cs = acc >= 792;
      if (cs) acc -= 792;
    end else cs = (cyc % 16) == 0;
    tc = tc_rand ? ($urandom_range(0, 3) == 0) : ((cyc % tc_div) == 0);
    sirq_clr = r; trig = t; pause = p; cen_sound = cs; trig_cen = tc;
    if (r) begin
      m_mode = 0; m_el = 0; m_coal = 0; m_pend = 0; m_prev = 0; m_flag = 0;
      #1 chk("async_clr", {30'd0, z80_n_int, state_o == 2'd0}, 32'd3);
      return;
    end
    e = tc && t && !m_prev;
    if (tc) m_prev = t;
    if (m_mode == 0) begin
      if (cs && (m_pend || e)) begin m_mode = 1; m_pend = 0; m_el = 0; end
      else if (e) m_pend = 1;
    end else if (m_mode == 1) begin
      if (e) m_coal = (m_coal < 15) ? m_coal + 1 : 15;
      if (cs && !p) begin
        m_el++;
        if (m_el == TO) begin m_mode = 2; m_flag = 1; m_el = 0; end
      end
    end else begin
      if (e) m_pend = 1;
      if (cs && !p) begin
        m_el++;
        if (m_el == HO) begin m_mode = 0; m_el = 0; end
      end
    end
  endtask
  initial begin
    int lat, pl;
    bit rt, rp;
    m_mode = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    // basic assertion then acknowledge
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    lat = 0;
    while (z80_n_int !== 1'b0 && lat < 40) begin step(0, 0, 0); lat++; end
    chk("basic_assert_in_budget", 32'(lat < 40), 32'd1);
    chk("basic_active", 32'(int_active), 32'd1);
    step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    // coalesce: 17 edges held in ASSERT by pause
    tc_div = 1;
    step(0, 1, 0); step(0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    for (int i = 0; i < 17; i++) begin step(0, 1, 1); step(0, 0, 1); end
    step(0, 0, 1);
    chk("coalesce_sat", 32'(coalesce_cnt), 32'd15);
    step(1, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    chk("no_reassert_after_ack", 32'(z80_n_int), 32'd1);
    chk("coalesce_cleared", 32'(coalesce_cnt), 32'd0);
    // timeout with an edge during holdoff
    for (int i = 0; i < 300; i++) step(0, (i < 2) || (i >= 170 && i < 172), 0);
    chk("timeout_flag_set", 32'(timeout_flag), 32'd1);
    step(1, 0, 0);
    // pause mid-assert
    for (int i = 0; i < 250; i++) step(0, i < 2, (i >= 40 && i < 120));
    step(1, 0, 0);
    // simultaneous edge and acknowledge
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    chk("edge_lost_in_clr", 32'(z80_n_int), 32'd1);
    // randomized run with fractional cen_sound
    frac = 1; tc_rand = 0; tc_div = 16;
    rt = 0; rp = 0; pl = 0;
    for (int i = 0; i < 20000; i++) begin
      if (i == 10000) tc_rand = 1;
      if ($urandom_range(0, 19) == 0) rt = ~rt;
      if (pl > 0) pl--; else begin rp = ($urandom_range(0, 300) == 0); pl = rp ? $urandom_range(10, 150) : 0; end
      step($urandom_range(0, 999) == 0, rt, rp);
    end
    step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
